// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_HALT
    } fetch_state_t;

    localparam logic [31:0] PC_STEP   = 32'd4;
    localparam logic [31:0] STOP_WORD = 32'h0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Memory, redirect and decode-side signals of the instruction fetch unit.
interface instruction_fetch_unit_if;

    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        halted;
    logic        misaligned;

    modport master (
        output imem_addr,
        input  imem_instr,
        input  redirect_valid,
        input  redirect_target,
        output out_valid,
        input  out_ready,
        output out_instr,
        output out_pc,
        output halted,
        output misaligned
    );

    modport slave (
        input  imem_addr,
        output imem_instr,
        output redirect_valid,
        output redirect_target,
        input  out_valid,
        output out_ready,
        input  out_instr,
        input  out_pc,
        input  halted,
        input  misaligned
    );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of {pc, instr} entries with flush; flush wins over push/pop.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    localparam int unsigned AW = $clog2(DEPTH),
    localparam int unsigned CW = $clog2(DEPTH + 1)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t wdata,
    output fetch_entry_t rdata,
    output logic         full,
    output logic         empty,
    output logic [CW-1:0] count
);

    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; entries are only visible through count.
    always_ff @(posedge clk) begin
        if (do_push && !flush && !reset) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch PC, stop/redirect control and decode-side output of the instruction FIFO.
module instruction_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0,
    parameter int unsigned BUF_DEPTH  = 2,
    parameter int unsigned IMEM_WORDS = 256
) (
    input logic                       clk,
    input logic                       reset,
    instruction_fetch_unit_if.master  bus
);

    localparam int unsigned CW       = $clog2(BUF_DEPTH + 1);
    localparam logic [31:0] PC_LIMIT = 32'(IMEM_WORDS * 4);

    fetch_state_t  state;
    fetch_state_t  state_next;
    logic [31:0]   fetch_pc;
    logic [31:0]   pc_next;
    logic          push;
    logic          pop;
    logic          flush;
    logic          full;
    logic          empty;
    logic [CW-1:0] count;
    logic [CW-1:0] count_after_pop;
    logic          stop_seen;
    logic          misaligned_r;
    fetch_entry_t  head;
    fetch_entry_t  new_entry;

    assign pop             = !empty && bus.out_ready;
    assign count_after_pop = count - CW'(pop);
    assign stop_seen       = (bus.imem_instr == STOP_WORD) || (fetch_pc >= PC_LIMIT);
    assign new_entry       = '{pc: fetch_pc, instr: bus.imem_instr};

    fetch_fifo #(.DEPTH(BUF_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .wdata (new_entry),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    // Redirect overrides everything; a same-cycle pop still completes before the flush.
    always_comb begin
        state_next = state;
        pc_next    = fetch_pc;
        push       = 1'b0;
        flush      = 1'b0;
        if (bus.redirect_valid) begin
            flush      = 1'b1;
            pc_next    = align_word(bus.redirect_target);
            state_next = ST_RUN;
        end else begin
            case (state)
                ST_RUN: begin
                    if (stop_seen) begin
                        state_next = (count_after_pop != '0) ? ST_DRAIN : ST_HALT;
                    end else if (!full || pop) begin
                        push    = 1'b1;
                        pc_next = fetch_pc + PC_STEP;
                    end
                end
                ST_DRAIN: begin
                    if (count_after_pop == '0) state_next = ST_HALT;
                end
                default: state_next = state;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_RUN;
            fetch_pc     <= RESET_PC;
            misaligned_r <= 1'b0;
        end else begin
            state    <= state_next;
            fetch_pc <= pc_next;
            if (bus.redirect_valid && (bus.redirect_target[1:0] != 2'b00))
                misaligned_r <= 1'b1;
        end
    end

    assign bus.imem_addr  = fetch_pc;
    assign bus.out_valid  = !empty;
    assign bus.out_instr  = empty ? 32'h0 : head.instr;
    assign bus.out_pc     = empty ? 32'h0 : head.pc;
    assign bus.halted     = (state == ST_HALT);
    assign bus.misaligned = misaligned_r;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: vector table plus redirect/halt/reset sequences.
module tb_instruction_fetch_unit;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad = 0;
    logic [31:0] acc [$];

    always #5 clk = ~clk;

    instruction_fetch_unit_if bus ();

    instruction_fetch_unit #(
        .RESET_PC   (32'h0),
        .BUF_DEPTH  (2),
        .IMEM_WORDS (256)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Memory model: words 0..11 non-zero, word 12 is the stop word, rest non-zero.
    function automatic logic [31:0] memval(input logic [31:0] addr);
        if (addr >= 32'h400) return 32'hFFFF_FFFF;
        if (addr[9:2] == 8'd12) return 32'h0;
        return 32'h1300_0000 | {24'h0, addr[9:2]};
    endfunction

    assign bus.imem_instr = memval(bus.imem_addr);

    always @(posedge clk) begin
        if (!reset && bus.out_valid && bus.out_ready) acc.push_back(bus.out_pc);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        rst;
        logic        rdy;
        logic        ev;
        logic [31:0] epc;
        logic [31:0] eaddr;
        logic        eh;
    } vec_t;

    vec_t tbl [$];

    function automatic vec_t mk(input logic rst, input logic rdy, input logic ev,
                                input logic [31:0] epc, input logic [31:0] eaddr,
                                input logic eh);
        vec_t v;
        v.rst = rst; v.rdy = rdy; v.ev = ev; v.epc = epc; v.eaddr = eaddr; v.eh = eh;
        return v;
    endfunction

    initial begin
        reset               = 1'b1;
        bus.out_ready       = 1'b0;
        bus.redirect_valid  = 1'b0;
        bus.redirect_target = 32'h0;

        // Reset, five cycles of backpressure, then straight-line drain to the stop word.
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b0, 1'b1, 32'h0, 32'h4, 1'b0));
        for (int i = 0; i < 4; i++) tbl.push_back(mk(1'b0, 1'b0, 1'b1, 32'h0, 32'h8, 1'b0));
        for (int k = 1; k <= 11; k++) begin
            logic [31:0] a;
            a = 32'(4 * k + 8);
            if (a > 32'h30) a = 32'h30;
            tbl.push_back(mk(1'b0, 1'b1, 1'b1, 32'(4 * k), a, 1'b0));
        end
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 32'h0, 32'h30, 1'b1));
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 32'h0, 32'h30, 1'b1));

        foreach (tbl[i]) begin
            reset         = tbl[i].rst;
            bus.out_ready = tbl[i].rdy;
            step();
            chk($sformatf("v%0d_valid", i), 32'(bus.out_valid), 32'(tbl[i].ev));
            chk($sformatf("v%0d_addr", i), bus.imem_addr, tbl[i].eaddr);
            chk($sformatf("v%0d_halted", i), 32'(bus.halted), 32'(tbl[i].eh));
            if (tbl[i].ev) begin
                chk($sformatf("v%0d_pc", i), bus.out_pc, tbl[i].epc);
                chk($sformatf("v%0d_instr", i), bus.out_instr, memval(tbl[i].epc));
            end
            if (tbl[i].rst) begin
                chk("reset_pc", bus.out_pc, 32'h0);
                chk("reset_instr", bus.out_instr, 32'h0);
                chk("reset_misaligned", 32'(bus.misaligned), 32'h0);
                acc.delete();
            end
        end

        chk("bp_count", 32'(acc.size()), 32'd12);
        for (int i = 0; i < 12; i++) begin
            if (i < acc.size()) chk($sformatf("bp_order%0d", i), acc[i], 32'(4 * i));
        end

        // Redirect in the same cycle as popping pc 0x04.
        reset = 1'b1; bus.out_ready = 1'b1;
        step();
        reset = 1'b0;
        acc.delete();
        step();
        chk("rd_pc0", bus.out_pc, 32'h0);
        step();
        chk("rd_pc4", bus.out_pc, 32'h4);
        bus.redirect_valid  = 1'b1;
        bus.redirect_target = 32'h20;
        step();
        bus.redirect_valid = 1'b0;
        chk("rd_flush_valid", 32'(bus.out_valid), 32'h0);
        chk("rd_addr", bus.imem_addr, 32'h20);
        chk("rd_consumed_n", 32'(acc.size()), 32'd2);
        if (acc.size() > 0) chk("rd_consumed_last", acc[acc.size() - 1], 32'h4);
        step();
        chk("rd_new_valid", 32'(bus.out_valid), 32'h1);
        chk("rd_new_pc", bus.out_pc, 32'h20);
        chk("rd_new_instr", bus.out_instr, memval(32'h20));

        // Run to halt, then restart by redirect.
        for (int i = 0; i < 40 && !bus.halted; i++) step();
        chk("h_halted", 32'(bus.halted), 32'h1);
        chk("h_addr", bus.imem_addr, 32'h30);
        if (acc.size() > 0) chk("h_last_pop", acc[acc.size() - 1], 32'h2C);
        bus.redirect_valid  = 1'b1;
        bus.redirect_target = 32'h10;
        step();
        bus.redirect_valid = 1'b0;
        chk("rs_halted", 32'(bus.halted), 32'h0);
        chk("rs_addr", bus.imem_addr, 32'h10);
        step();
        chk("rs_valid", 32'(bus.out_valid), 32'h1);
        chk("rs_pc", bus.out_pc, 32'h10);

        // Misaligned redirect near the top of memory, then the range stop.
        bus.redirect_valid  = 1'b1;
        bus.redirect_target = 32'h3FE;
        step();
        bus.redirect_valid = 1'b0;
        chk("ma_flag", 32'(bus.misaligned), 32'h1);
        chk("ma_addr", bus.imem_addr, 32'h3FC);
        step();
        chk("ma_pc", bus.out_pc, 32'h3FC);
        chk("ma_instr", bus.out_instr, memval(32'h3FC));
        chk("ma_range_addr", bus.imem_addr, 32'h400);
        step();
        chk("ma_halted", 32'(bus.halted), 32'h1);
        chk("ma_valid", 32'(bus.out_valid), 32'h0);
        chk("ma_hold_addr", bus.imem_addr, 32'h400);

        // Reset with two entries buffered.
        reset = 1'b1;
        step();
        reset = 1'b0; bus.out_ready = 1'b0;
        step();
        step();
        chk("mr_full_addr", bus.imem_addr, 32'h8);
        chk("mr_full_valid", 32'(bus.out_valid), 32'h1);
        reset = 1'b1;
        step();
        chk("mr_valid", 32'(bus.out_valid), 32'h0);
        chk("mr_addr", bus.imem_addr, 32'h0);
        chk("mr_misaligned", 32'(bus.misaligned), 32'h0);
        reset = 1'b0; bus.out_ready = 1'b1;
        step();
        chk("mr_restart_pc", bus.out_pc, 32'h0);
        chk("mr_restart_addr", bus.imem_addr, 32'h4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
